// File: rtl/memory_stage_pkg.sv
// Shared types for the MEM-stage controller: word/register types and the
// dcache access FSM encoding.
package memory_stage_pkg;

  localparam int WORD_W_DEF      = 32;
  localparam int REG_W_DEF       = 5;
  localparam int STALL_CNT_W_DEF = 16;

  typedef logic [WORD_W_DEF-1:0] word_t;
  typedef logic [REG_W_DEF-1:0]  regbits_t;

  // Plain-constant state encoding so older tools and netlists read it directly.
  typedef logic [1:0] mem_state_t;
  localparam mem_state_t IDLE   = 2'd0;
  localparam mem_state_t ACCESS = 2'd1;
  localparam mem_state_t DONE   = 2'd2;

  function automatic logic branch_taken(input logic beq_en,
                                        input logic bne_en,
                                        input logic equal);
    return (beq_en & equal) | (bne_en & ~equal);
  endfunction

endpackage

// File: rtl/memory_stage.sv
// MEM-stage controller: issues dcache requests, stalls the pipe until dhit,
// resolves redirects and selects the MEM/WB write-back value.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int REG_W       = REG_W_DEF,
  parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   pipe_en,
  input  logic                   mem_to_reg,
  input  logic                   mem_wr,
  input  logic                   d_atomic,
  input  logic [WORD_W-1:0]      alu_result,
  input  logic [WORD_W-1:0]      bus_b,
  input  logic [WORD_W-1:0]      imm_32,
  input  logic [WORD_W-1:0]      next_pc,
  input  logic [WORD_W-1:0]      branch_pc,
  input  logic [WORD_W-1:0]      jump_pc,
  input  logic [WORD_W-1:0]      jump_r_pc,
  input  logic                   beq_en,
  input  logic                   bne_en,
  input  logic                   equal,
  input  logic                   jump_en,
  input  logic                   jr_en,
  input  logic                   jal_en,
  input  logic                   lui_en,
  input  logic                   halt_in,
  input  logic                   reg_wr,
  input  logic [REG_W-1:0]       reg_wr_addr,
  input  logic                   dhit,
  input  logic [WORD_W-1:0]      dmemload,
  output logic                   dmemREN,
  output logic                   dmemWEN,
  output logic                   datomic,
  output logic [WORD_W-1:0]      dmemaddr,
  output logic [WORD_W-1:0]      dmemstore,
  output logic                   mem_stall,
  output logic                   redirect_en,
  output logic [WORD_W-1:0]      redirect_pc,
  output logic [WORD_W-1:0]      wb_data,
  output logic                   wb_reg_wr,
  output logic [REG_W-1:0]       wb_addr,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  mem_state_t        state;
  mem_state_t        state_next;
  logic [WORD_W-1:0] load_q;
  logic              load_en;
  logic              req;
  logic              issuing;
  logic              ren_raw;
  logic              wen_raw;
  logic              stall_raw;
  logic              taken;
  logic              redirect_req;
  logic              mem_result;

  assign req     = (mem_to_reg | mem_wr) & ~halted;
  // DONE keeps the strobes low while MEM/WB is held, so a completed access is
  // never re-issued to the cache.
  assign issuing = (state != DONE) & req;

  assign ren_raw   = issuing & mem_to_reg;
  assign wen_raw   = issuing & mem_wr & ~mem_to_reg;
  assign stall_raw = issuing & ~dhit;

  // Request strobes and control pulses drop the moment nRST asserts, even
  // while an access is outstanding, rather than waiting for the state to clear.
  assign dmemREN   = nRST & ren_raw;
  assign dmemWEN   = nRST & wen_raw;
  assign mem_stall = nRST & stall_raw;
  assign datomic   = d_atomic & (dmemREN | dmemWEN);
  assign dmemaddr  = alu_result;
  assign dmemstore = bus_b;

  assign taken        = branch_taken(beq_en, bne_en, equal);
  assign redirect_req = jr_en | jump_en | taken;
  assign redirect_en  = nRST & redirect_req & pipe_en & ~stall_raw & ~halted;

  always_comb begin
    if (jr_en)
      redirect_pc = jump_r_pc;
    else if (jump_en || jal_en)
      redirect_pc = jump_pc;
    else
      redirect_pc = branch_pc;
  end

  // SC returns its success flag through dmemload, so it writes back like a load.
  assign mem_result = mem_to_reg | (mem_wr & d_atomic);

  always_comb begin
    if (jal_en)
      wb_data = next_pc;
    else if (lui_en)
      wb_data = imm_32;
    else if (mem_result)
      wb_data = (state == DONE) ? load_q : dmemload;
    else
      wb_data = alu_result;
  end

  assign wb_reg_wr = reg_wr & ~halted;
  assign wb_addr   = reg_wr_addr;

  // A one-cycle hit in IDLE follows exactly the same completion rules as a
  // hit in ACCESS; pipe_en only matters once the stall has cleared.
  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips an assignment would infer a latch.
    state_next = state;
    load_en    = 1'b0;
    unique case (state)
      IDLE, ACCESS: begin
        if (!req) begin
          state_next = IDLE;
        end else if (dhit) begin
          load_en    = 1'b1;
          state_next = pipe_en ? IDLE : DONE;
        end else begin
          state_next = ACCESS;
        end
      end
      DONE: begin
        if (pipe_en)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      state <= IDLE;
    else
      state <= state_next;
  end

  // NOTE: load_q is reset even though DONE is unreachable without a fresh
  // capture; a defined value keeps wb_data clean in simulation and netlists.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      load_q <= '0;
    else if (load_en)
      load_q <= dmemload;
  end

  // pipe_en asserted during a stall is a hazard-unit fault and must not retire
  // a halt.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      halted <= 1'b0;
    else if (halt_in && pipe_en && !stall_raw)
      halted <= 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      stall_cycles <= '0;
    else if (stall_raw && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule
